clk_step_ctrl: RTL and testbench

//  Sequences the processor clock-enable from the pushbutton pulses produced by Gen_Pulso.

---
 rtl/clk_step_ctrl_pkg.sv | 14 +
 rtl/clk_step_ctrl_key_edge_sync.sv | 37 +++
 rtl/clk_step_ctrl.sv | 107 ++++++++++
 tb/tb_clk_step_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/clk_step_ctrl_pkg.sv
// Shared state codes for the clock-step controller and its display decoder.
package clk_step_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_STEP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_STEP = ST_STEP,
        S_RUN  = ST_RUN
    } step_state_t;

endpackage

// File: rtl/clk_step_ctrl_key_edge_sync.sv
// Synchronises one pushbutton level into CLK and emits a one-cycle rising-edge pulse.
module key_edge_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic KEY,
    output logic EDGE
);

    logic       k1;
    logic       k2;
    logic       k3;
    logic       armed;
    logic [1:0] fill;

    // fill[1] marks the first cycle k2 holds a real KEY sample rather than its
    // reset value, so a key held through reset release never arms the detector.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            k1    <= 1'b0;
            k2    <= 1'b0;
            k3    <= 1'b0;
            armed <= 1'b0;
            fill  <= 2'b00;
        end else begin
            k1   <= KEY;
            k2   <= k1;
            k3   <= k2;
            fill <= {fill[0], 1'b1};
            if (fill[1] && !k2) begin
                armed <= 1'b1;
            end
        end
    end

    assign EDGE = k2 & ~k3 & armed;

endmodule

// File: rtl/clk_step_ctrl.sv
// Processor clock-enable sequencer: halted, divided free-run, or single-step per key press.
module clk_step_ctrl
    import clk_step_ctrl_pkg::*;
#(
    parameter int RUN_DIV = 1000000,
    parameter int DIV_W   = 20,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             KEY_STEP,
    input  logic             KEY_RUN,
    input  logic             HALT_REQ,
    input  logic             CLR_CNT,
    output logic             CPU_EN,
    output logic             RUNNING,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] STEP_CNT
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic             step_edge;
    logic             run_edge;
    step_state_t      state;
    step_state_t      state_n;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_n;
    logic             cpu_en_n;
    logic [CNT_W-1:0] step_cnt;

    key_edge_sync u_step_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .KEY   (KEY_STEP),
        .EDGE  (step_edge)
    );

    key_edge_sync u_run_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .KEY   (KEY_RUN),
        .EDGE  (run_edge)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_IDLE;
            div     <= '0;
            CPU_EN  <= 1'b0;
            RUNNING <= 1'b0;
        end else begin
            state   <= state_n;
            div     <= div_n;
            CPU_EN  <= cpu_en_n;
            RUNNING <= (state_n == S_RUN);
        end
    end

    // A halted processor still accepts single steps; only entry to RUN is blocked.
    always_comb begin
        state_n  = state;
        div_n    = div;
        cpu_en_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (run_edge && !HALT_REQ) begin
                    state_n = S_RUN;
                    div_n   = '0;
                end else if (step_edge) begin
                    state_n  = S_STEP;
                    cpu_en_n = 1'b1;
                end
            end
            S_STEP: begin
                state_n = S_IDLE;
            end
            S_RUN: begin
                if (HALT_REQ || run_edge) begin
                    state_n = S_IDLE;
                    div_n   = '0;
                end else if (div == DIV_LAST) begin
                    div_n    = '0;
                    cpu_en_n = 1'b1;
                end else begin
                    div_n = div + DIV_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                div_n   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET || CLR_CNT) begin
            step_cnt <= '0;
        end else if (CPU_EN) begin
            step_cnt <= step_cnt + CNT_W'(1);
        end
    end

    assign STATE    = state;
    assign STEP_CNT = step_cnt;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed bench for clk_step_ctrl: cycle tables plus multi-cycle key/reset/wrap sequences.
module tb_clk_step_ctrl;
    import clk_step_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, ks, kr, halt, clr;
    logic        en, running;
    logic [1:0]  st;
    logic [15:0] cnt;

    logic        w_rst, w_ks, w_kr, w_halt, w_clr;
    logic        w_en, w_running;
    logic [1:0]  w_st;
    logic [15:0] w_cnt;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int first_pulse;

    always #5 clk = ~clk;

    clk_step_ctrl #(.RUN_DIV(4), .DIV_W(20), .CNT_W(16)) dut (
        .CLK(clk), .RESET(rst), .KEY_STEP(ks), .KEY_RUN(kr), .HALT_REQ(halt),
        .CLR_CNT(clr), .CPU_EN(en), .RUNNING(running), .STATE(st), .STEP_CNT(cnt)
    );

    clk_step_ctrl #(.RUN_DIV(1), .DIV_W(20), .CNT_W(16)) u_wrap (
        .CLK(clk), .RESET(w_rst), .KEY_STEP(w_ks), .KEY_RUN(w_kr), .HALT_REQ(w_halt),
        .CLR_CNT(w_clr), .CPU_EN(w_en), .RUNNING(w_running), .STATE(w_st), .STEP_CNT(w_cnt)
    );

    typedef struct {
        logic        ks, kr, halt, clr;
        logic        en;
        logic [1:0]  st;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic a_ks, a_kr, a_halt, a_clr, a_en,
                       input logic [1:0] a_st, input logic [15:0] a_cnt);
        vec_t v;
        v.ks = a_ks; v.kr = a_kr; v.halt = a_halt; v.clr = a_clr;
        v.en = a_en; v.st = a_st; v.cnt = a_cnt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample just after the active edge; inputs change here too, well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (en) pulses++;
    endtask

    initial begin
        rst = 1'b1; ks = 0; kr = 0; halt = 0; clr = 0;
        w_rst = 1'b1; w_ks = 0; w_kr = 0; w_halt = 0; w_clr = 0;

        // ks kr halt clr | en state cnt
        // RUN entry, 4-cycle pulses, exit on a divider-wrap cycle
        add(0,1,0,0, 0,ST_IDLE,1); add(0,1,0,0, 0,ST_IDLE,1); add(0,0,0,0, 0,ST_RUN,1);
        add(0,0,0,0, 0,ST_RUN,1);  add(0,0,0,0, 0,ST_RUN,1);  add(0,0,0,0, 0,ST_RUN,1);
        add(0,0,0,0, 1,ST_RUN,1);  add(0,0,0,0, 0,ST_RUN,2);  add(0,0,0,0, 0,ST_RUN,2);
        add(0,0,0,0, 0,ST_RUN,2);  add(0,0,0,0, 1,ST_RUN,2);  add(0,0,0,0, 0,ST_RUN,3);
        add(0,1,0,0, 0,ST_RUN,3);  add(0,1,0,0, 0,ST_RUN,3);  add(0,0,0,0, 0,ST_IDLE,3);
        add(0,0,0,0, 0,ST_IDLE,3); add(0,0,0,0, 0,ST_IDLE,3); add(0,0,0,0, 0,ST_IDLE,3);
        add(0,0,0,0, 0,ST_IDLE,3);
        // HALT on wrap cycle, RUN blocked by HALT, STEP allowed under HALT
        add(0,1,0,0, 0,ST_IDLE,3); add(0,1,0,0, 0,ST_IDLE,3); add(0,0,0,0, 0,ST_RUN,3);
        add(0,0,0,0, 0,ST_RUN,3);  add(0,0,0,0, 0,ST_RUN,3);  add(0,0,0,0, 0,ST_RUN,3);
        add(0,0,1,0, 0,ST_IDLE,3); add(0,0,1,0, 0,ST_IDLE,3); add(0,1,1,0, 0,ST_IDLE,3);
        add(0,1,1,0, 0,ST_IDLE,3); add(0,0,1,0, 0,ST_IDLE,3); add(0,0,1,0, 0,ST_IDLE,3);
        add(0,0,1,0, 0,ST_IDLE,3); add(1,0,1,0, 0,ST_IDLE,3); add(1,0,1,0, 0,ST_IDLE,3);
        add(0,0,1,0, 1,ST_STEP,3); add(0,0,1,0, 0,ST_IDLE,4); add(0,0,1,0, 0,ST_IDLE,4);
        add(0,0,0,0, 0,ST_IDLE,4); add(0,0,0,0, 0,ST_IDLE,4);
        // STEP and RUN together from IDLE; step edge ignored while running
        add(1,1,0,0, 0,ST_IDLE,4); add(1,1,0,0, 0,ST_IDLE,4); add(0,0,0,0, 0,ST_RUN,4);
        add(1,0,0,0, 0,ST_RUN,4);  add(1,0,0,0, 0,ST_RUN,4);  add(0,0,0,0, 0,ST_RUN,4);
        add(0,0,0,0, 1,ST_RUN,4);  add(0,1,0,0, 0,ST_RUN,5);  add(0,1,0,0, 0,ST_RUN,5);
        add(0,0,0,0, 0,ST_IDLE,5); add(0,0,0,0, 0,ST_IDLE,5); add(0,0,0,0, 0,ST_IDLE,5);
        add(0,0,0,0, 0,ST_IDLE,5);
        // CLR_CNT coincident with CPU_EN
        add(1,0,0,0, 0,ST_IDLE,5); add(1,0,0,0, 0,ST_IDLE,5); add(0,0,0,0, 1,ST_STEP,5);
        add(0,0,0,1, 0,ST_IDLE,0); add(0,0,0,0, 0,ST_IDLE,0);

        // Reset state
        tick(); tick();
        chk("reset_en", en, 0); chk("reset_state", st, ST_IDLE);
        chk("reset_running", running, 0); chk("reset_cnt", cnt, 0);
        rst = 1'b0; w_rst = 1'b0;
        repeat (3) tick();

        // Single step with a 1000 ns hold: one pulse on the third edge after sampling
        pulses = 0; first_pulse = -1;
        ks = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (en && first_pulse < 0) first_pulse = i;
        end
        ks = 1'b0;
        repeat (5) tick();
        chk("step_pulse_count", pulses, 1);
        chk("step_latency", first_pulse, 2);
        chk("step_cnt", cnt, 1);
        chk("step_back_idle", st, ST_IDLE);

        foreach (tbl[i]) begin
            ks = tbl[i].ks; kr = tbl[i].kr; halt = tbl[i].halt; clr = tbl[i].clr;
            tick();
            chk($sformatf("vec%0d_en", i), en, tbl[i].en);
            chk($sformatf("vec%0d_state", i), st, tbl[i].st);
            chk($sformatf("vec%0d_running", i), running, tbl[i].st == ST_RUN);
            chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].cnt);
        end
        ks = 0; kr = 0; halt = 0; clr = 0;

        // RESET mid-RUN on a divider-wrap edge
        kr = 1'b1; tick(); tick(); kr = 1'b0; tick();
        chk("rr_entered", st, ST_RUN);
        repeat (7) tick();
        chk("rr_cnt_before", cnt, 1);
        rst = 1'b1; tick();
        chk("rr_en", en, 0); chk("rr_state", st, ST_IDLE);
        chk("rr_running", running, 0); chk("rr_cnt", cnt, 0);
        tick();

        // Key held high across reset release
        ks = 1'b1; tick();
        rst = 1'b0;
        pulses = 0;
        repeat (20) tick();
        chk("held_no_pulse", pulses, 0);
        chk("held_state", st, ST_IDLE);
        ks = 1'b0; repeat (5) tick();
        pulses = 0;
        ks = 1'b1; tick(); tick(); ks = 1'b0;
        repeat (4) tick();
        chk("held_then_press", pulses, 1);
        chk("held_then_cnt", cnt, 1);

        // STEP_CNT wrap on a RUN_DIV=1 instance: CPU_EN every cycle while running
        w_kr = 1'b1; tick(); tick(); w_kr = 1'b0; tick();
        chk("wrap_run", w_st, ST_RUN);
        begin
            int n = 0;
            while (!w_en && n < 20) begin tick(); n++; end
        end
        chk("wrap_first_en", w_en, 1);
        repeat (65534) tick();
        w_halt = 1'b1; tick(); w_halt = 1'b0;
        chk("wrap_cnt_ffff", w_cnt, 16'hFFFF);
        chk("wrap_halted_en", w_en, 0);
        repeat (3) tick();
        w_ks = 1'b1; tick(); tick(); w_ks = 1'b0; tick();
        chk("wrap_step_en", w_en, 1);
        tick();
        chk("wrap_cnt_zero", w_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
